// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_arbiter
// Purpose  : Round-robin arbiter driving the select pins of a shared MUX16,
//            with optional per-grant hold limit.
// Revision : 1.0  initial release
// ============================================================================
module mux16_rr_arbiter #(
   parameter int HOLD_MAX = 0
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic [15:0] REQ,
   output logic [15:0] GNT,
   output logic [3:0]  SEL,
   output logic        GNT_VLD
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   localparam logic [7:0] c_HOLD_MAX = 8'(HOLD_MAX);

   state_t      state_q;
   logic [15:0] gnt_q;
   logic [3:0]  sel_q;
   logic [3:0]  ptr_q;
   logic [7:0]  hcnt_q;

   logic [3:0]  w_start;
   logic [15:0] w_mask;
   logic        w_found;
   logic [3:0]  w_win;
   logic        w_own;
   logic        w_limit;

   // While owned, the search starts just past the owner and never re-picks it.
   assign w_start = (state_q == OWNED) ? (sel_q + 4'd1) : ptr_q;
   assign w_mask  = (state_q == OWNED) ? (REQ & ~(16'd1 << sel_q)) : REQ;
   assign w_own   = REQ[sel_q];
   assign w_limit = (c_HOLD_MAX != 8'd0) && (hcnt_q >= c_HOLD_MAX);

   always_comb begin
      w_found = 1'b0;
      w_win   = w_start;
      // Descending scan: the smallest wrapped offset from w_start wins last.
      for (int i = 15; i >= 0; i--) begin
         if (w_mask[w_start + 4'(i)]) begin
            w_found = 1'b1;
            w_win   = w_start + 4'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         hcnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_found) begin
                  state_q <= OWNED;
                  gnt_q   <= 16'd1 << w_win;
                  sel_q   <= w_win;
                  hcnt_q  <= 8'd1;
               end
            end
            OWNED: begin
               if (!w_own || (w_limit && w_found)) begin
                  ptr_q <= sel_q + 4'd1;
                  if (w_found) begin
                     gnt_q  <= 16'd1 << w_win;
                     sel_q  <= w_win;
                     hcnt_q <= 8'd1;
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                  end
               end else if (w_limit) begin
                  hcnt_q <= 8'd1;
               end else if (hcnt_q != 8'hFF) begin
                  hcnt_q <= hcnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign GNT     = gnt_q;
   assign SEL     = sel_q;
   assign GNT_VLD = (state_q == OWNED);

endmodule
`default_nettype wire
